pipe_hazard_ctrl: RTL

- Parametrised hazard, interlock and flush controller for the in-order RISC-V pipeline.
- Keeps a shadow scoreboard of in-flight destination registers for every pipeline register after ID, and drives the per-register enable, bubble and flush controls.
- Generates registered operand-forwarding selects for EX.
- Replaces the ad-hoc stall and flush logic in the processor top. It generalises the design to any depth, a configurable branch-resolve point and a configurable load latency.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/hazard_match.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout,
// forwarding-select encoding and the bubble constant.
package pipe_pkg;

   // Scoreboard rd field is sized for the widest supported register index;
   // narrower indices are zero-extended on entry.
   localparam int RD_W_MAX  = 8;
   localparam int FWD_W_MAX = 4;

   typedef logic [RD_W_MAX-1:0]  sb_rd_t;
   typedef logic [FWD_W_MAX-1:0] fwd_sel_t;

   typedef struct packed {
      logic   valid;
      logic   reg_wr;
      sb_rd_t rd;
      logic   is_load;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   // Forwarding code for a result sitting in scoreboard entry k.
   function automatic fwd_sel_t fwd_code(input fwd_sel_t k);
      return k + fwd_sel_t'(1);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source index against the checked scoreboard entries and
// reports whether any match, the youngest matching entry and whether it is a load.
module hazard_match
   import pipe_pkg::*;
#(
   parameter int NCHK      = 2,
   parameter int REG_IDX_W = 5
) (
   input  sb_entry_t              entries [NCHK],
   input  logic [REG_IDX_W-1:0]   rs,
   input  logic                   rs_used,
   output logic                   hit,
   output fwd_sel_t               idx,
   output logic                   is_load
);

   logic [NCHK-1:0] match;

   generate
      for (genvar gi = 0; gi < NCHK; gi++) begin : g_match
         assign match[gi] = entries[gi].valid && entries[gi].reg_wr && rs_used &&
                            (entries[gi].rd == sb_rd_t'(rs)) && (rs != '0);
      end
   endgenerate

   // Scan oldest to youngest so the lowest matching index is what remains.
   always_comb begin
      hit     = 1'b0;
      idx     = '0;
      is_load = 1'b0;
      for (int k = NCHK - 1; k >= 0; k--) begin
         if (match[k]) begin
            hit     = 1'b1;
            idx     = fwd_sel_t'(k);
            is_load = entries[k].is_load;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, interlock and flush controller built around a shadow scoreboard of in-flight
// destinations. Define PIPE_FORWARDING_EN to enable EX forwarding with load-use-only interlocks.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int  NSTAGES    = 5,
   parameter int  REG_IDX_W  = 5,
   parameter int  BR_ENTRY   = 1,
   parameter int  LOAD_READY = 2,
   parameter int  CNT_W      = 32,
   localparam int D          = NSTAGES - 2,
   localparam int FWD_W      = $clog2(D) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 id_reg_wr,
   input  logic                 id_rd_mem,
   input  logic                 br_taken,
   input  logic                 mem_stall,
   output logic                 staller,
   output logic                 if_id_en,
   output logic                 if_id_flush,
   output logic                 id_ex_bubble,
   output logic [D-1:0]         entry_flush,
   output logic                 pipe_en,
   output logic [FWD_W-1:0]     fwd_sel_a,
   output logic [FWD_W-1:0]     fwd_sel_b,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   // The WB entry never needs checking: the register file is write-first.
   localparam int NCHK = D - 1;

   sb_entry_t        sb_reg  [D];
   sb_entry_t        sb_next [D];
   sb_entry_t        chk     [NCHK];
   sb_entry_t        id_entry;
   logic             hit_a, hit_b;
   logic             load_a, load_b;
   logic             load_use_a, load_use_b;
   fwd_sel_t         idx_a, idx_b;
   logic             hazard;
   logic             br_act;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   generate
      for (genvar gi = 0; gi < NCHK; gi++) begin : g_chk
         assign chk[gi] = sb_reg[gi];
      end
   endgenerate

   hazard_match #(
      .NCHK      (NCHK),
      .REG_IDX_W (REG_IDX_W)
   ) u_match_a (
      .entries (chk),
      .rs      (id_rs1),
      .rs_used (id_rs1_used),
      .hit     (hit_a),
      .idx     (idx_a),
      .is_load (load_a)
   );

   hazard_match #(
      .NCHK      (NCHK),
      .REG_IDX_W (REG_IDX_W)
   ) u_match_b (
      .entries (chk),
      .rs      (id_rs2),
      .rs_used (id_rs2_used),
      .hit     (hit_b),
      .idx     (idx_b),
      .is_load (load_b)
   );

   // A load in entry k has its data forwardable only once k+1 reaches LOAD_READY.
   assign load_use_a = hit_a && load_a && ((int'(idx_a) + 1) < LOAD_READY);
   assign load_use_b = hit_b && load_b && ((int'(idx_b) + 1) < LOAD_READY);

`ifdef PIPE_FORWARDING_EN
   assign hazard = load_use_a || load_use_b;
`else
   assign hazard = hit_a || hit_b;
`endif

   // A frozen pipe holds the branch in place, so it is acted on once mem_stall drops.
   assign br_act       = br_taken && !mem_stall;
   assign staller      = id_valid && hazard && !br_act;
   assign if_id_en     = !staller && !mem_stall;
   assign if_id_flush  = br_act;
   assign id_ex_bubble = br_act || staller;
   assign pipe_en      = !mem_stall;

   assign id_entry = '{valid: id_valid, reg_wr: id_reg_wr, rd: sb_rd_t'(id_rd), is_load: id_rd_mem};

   generate
      for (genvar gi = 0; gi < D; gi++) begin : g_sb
         assign entry_flush[gi] = br_act && (gi <= BR_ENTRY);
         if (gi == 0) begin : g_head
            assign sb_next[gi] = (id_ex_bubble || entry_flush[gi]) ? SB_BUBBLE : id_entry;
         end else begin : g_body
            assign sb_next[gi] = entry_flush[gi] ? SB_BUBBLE : sb_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < D; k++) sb_reg[k] <= SB_BUBBLE;
      end else if (!mem_stall) begin
         for (int k = 0; k < D; k++) sb_reg[k] <= sb_next[k];
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (staller && !mem_stall && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (br_act && (flush_cnt_reg != '1))
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

`ifdef PIPE_FORWARDING_EN
   fwd_sel_t         fwd_a_next, fwd_b_next;
   logic [FWD_W-1:0] fwd_a_reg, fwd_b_reg;
   logic             unused_bits;

   always_comb begin
      fwd_a_next = '0;
      fwd_b_next = '0;
      if (id_valid && !id_ex_bubble) begin
         if (hit_a) fwd_a_next = fwd_code(idx_a);
         if (hit_b) fwd_b_next = fwd_code(idx_b);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_a_reg <= '0;
         fwd_b_reg <= '0;
      end else if (!mem_stall) begin
         fwd_a_reg <= fwd_a_next[FWD_W-1:0];
         fwd_b_reg <= fwd_b_next[FWD_W-1:0];
      end
   end

   assign fwd_sel_a   = fwd_a_reg;
   assign fwd_sel_b   = fwd_b_reg;
   assign unused_bits = ^{fwd_a_next, fwd_b_next, sb_reg[D-1]};
`else
   logic unused_bits;

   assign fwd_sel_a   = '0;
   assign fwd_sel_b   = '0;
   assign unused_bits = ^{load_use_a, load_use_b, sb_reg[D-1]};
`endif

endmodule
